// File: rtl/bus_split.sv
// Splits one merged word into two independently drained output channels (da = upper, db = lower).
// Each channel holds one field; a new word is accepted only once both channels can take it.
module bus_split #(
  parameter int DA_W = 48,
  parameter int DB_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DA_W+DB_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DA_W-1:0]      da,
  output logic                 da_valid,
  input  logic                 da_ready,
  output logic [DB_W-1:0]      db,
  output logic                 db_valid,
  input  logic                 db_ready,
  output logic [15:0]          word_count
);

  // Handshake: a channel transfers on a rising edge where its valid and ready are both 1.
  // Valid never drops before its transfer, and data is held stable while valid & ~ready.

  // Channel occupancy: bit 1 = da full, bit 0 = db full.
  localparam logic [1:0] ST_EMPTY  = 2'b00;
  localparam logic [1:0] ST_B_ONLY = 2'b01;
  localparam logic [1:0] ST_A_ONLY = 2'b10;
  localparam logic [1:0] ST_BOTH   = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       in_fire;

  assign da_valid = state_q[1];
  assign db_valid = state_q[0];
  assign in_ready = (~da_valid | da_ready) & (~db_valid | db_ready);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      state_d = ST_BOTH;
    end else begin
      case (state_q)
        ST_BOTH: begin
          case ({da_ready, db_ready})
            2'b11:   state_d = ST_EMPTY;
            2'b10:   state_d = ST_B_ONLY;
            2'b01:   state_d = ST_A_ONLY;
            default: state_d = ST_BOTH;
          endcase
        end
        ST_A_ONLY: if (da_ready) state_d = ST_EMPTY;
        ST_B_ONLY: if (db_ready) state_d = ST_EMPTY;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      da         <= '0;
      db         <= '0;
      word_count <= 16'd0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        da         <= in_data[DA_W+DB_W-1:DB_W];
        db         <= in_data[DB_W-1:0];
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_split.sv
// Bench for bus_split: directed scenarios plus random back-pressure, with a per-channel
// expected queue filled on input acceptance and drained on each output transfer.
module tb_bus_split;

  localparam int DA_W = 48;
  localparam int DB_W = 64;
  localparam int W    = DA_W + DB_W;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DA_W-1:0] da;
  logic            da_valid;
  logic            da_ready;
  logic [DB_W-1:0] db;
  logic            db_valid;
  logic            db_ready;
  logic [15:0]     word_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DA_W-1:0] exp_da_q[$];
  logic [DB_W-1:0] exp_db_q[$];
  logic [15:0]     model_cnt;
  logic            prev_da_stall, prev_db_stall;
  logic [DA_W-1:0] prev_da;
  logic [DB_W-1:0] prev_db;

  bus_split #(.DA_W(DA_W), .DB_W(DB_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .da(da), .da_valid(da_valid), .da_ready(da_ready),
    .db(db), .db_valid(db_valid), .db_ready(db_ready),
    .word_count(word_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_da_q.delete();
      exp_db_q.delete();
      model_cnt     = 16'd0;
      prev_da_stall = 1'b0;
      prev_db_stall = 1'b0;
    end else begin
      check("word_count", 128'(word_count), 128'(model_cnt));
      if (prev_da_stall) check("da_hold", 128'({da_valid, da}), 128'({1'b1, prev_da}));
      if (prev_db_stall) check("db_hold", 128'({db_valid, db}), 128'({1'b1, prev_db}));
      if (da_valid && da_ready) begin
        if (exp_da_q.size() == 0) check("da_stale", 128'(1), 128'(0));
        else check("da_data", 128'(da), 128'(exp_da_q.pop_front()));
      end
      if (db_valid && db_ready) begin
        if (exp_db_q.size() == 0) check("db_stale", 128'(1), 128'(0));
        else check("db_data", 128'(db), 128'(exp_db_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_da_q.push_back(in_data[W-1:DB_W]);
        exp_db_q.push_back(in_data[DB_W-1:0]);
        model_cnt = model_cnt + 16'd1;
      end
      prev_da_stall = da_valid && !da_ready;
      prev_db_stall = db_valid && !db_ready;
      prev_da       = da;
      prev_db       = db;
    end
  end

  logic [W-1:0] w1, w2;
  logic         acc;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    da_ready = 1'b0;
    db_ready = 1'b0;
    tick();
    check("rst_da_valid", 128'(da_valid), 128'(0));
    check("rst_db_valid", 128'(db_valid), 128'(0));
    check("rst_da", 128'(da), 128'(0));
    check("rst_db", 128'(db), 128'(0));
    check("rst_count", 128'(word_count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    tick();
    rst_n = 1'b1;

    // basic split
    da_ready = 1'b1; db_ready = 1'b1;
    in_data  = {48'hFFFFFFFFFFFF, 64'h0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("basic_da", 128'(da), 128'(48'hFFFFFFFFFFFF));
    check("basic_db", 128'(db), 128'(64'h0));
    check("basic_valids", 128'({da_valid, db_valid}), 128'(2'b11));
    check("basic_count", 128'(word_count), 128'(1));
    tick();
    check("drain_valids", 128'({da_valid, db_valid}), 128'(2'b00));
    check("drain_hold_da", 128'(da), 128'(48'hFFFFFFFFFFFF));

    // opposite split
    in_data  = {48'h0, 64'hFFFFFFFFFFFFFFFF};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("opp_da", 128'(da), 128'(0));
    check("opp_db", 128'(db), 128'(64'hFFFFFFFFFFFFFFFF));
    check("opp_count", 128'(word_count), 128'(2));
    tick();

    // stalled db channel
    w1 = rand_word();
    w2 = rand_word();
    da_ready = 1'b1; db_ready = 1'b0;
    in_data  = w1;
    in_valid = 1'b1;
    tick();
    in_data = w2;
    check("stall_both", 128'({da_valid, db_valid}), 128'(2'b11));
    check("stall_rdy0", 128'(in_ready), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_da_drop", 128'(da_valid), 128'(0));
      check("stall_rdy", 128'(in_ready), 128'(0));
      check("stall_db", 128'(db), 128'(w1[DB_W-1:0]));
    end
    db_ready = 1'b1;
    #1;
    check("unstall_rdy", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("unstall_valids", 128'({da_valid, db_valid}), 128'(2'b11));
    check("unstall_da", 128'(da), 128'(w2[W-1:DB_W]));
    check("unstall_db", 128'(db), 128'(w2[DB_W-1:0]));
    tick();

    // back-to-back streaming from a fresh reset
    do_reset();
    da_ready = 1'b1; db_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = rand_word();
      #1;
      check("stream_rdy", 128'(in_ready), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", 128'(word_count), 128'(10));
    tick();

    // random traffic with back-pressure; data held while not accepted
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_word();
      end
      da_ready = ($urandom_range(0, 2) != 0);
      db_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    da_ready = 1'b1; db_ready = 1'b1;
    tick();
    tick();

    // reset with both channels full and stalled
    da_ready = 1'b0; db_ready = 1'b0;
    in_data  = rand_word();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valids", 128'({da_valid, db_valid}), 128'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", 128'({da_valid, db_valid}), 128'(2'b00));
    check("mid_rst_count", 128'(word_count), 128'(0));
    tick();
    rst_n = 1'b1;
    da_ready = 1'b1; db_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valids", 128'({da_valid, db_valid}), 128'(2'b00));
    end

    // counter wrap after 65536 transfers
    do_reset();
    da_ready = 1'b1; db_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = rand_word();
      tick();
    end
    in_valid = 1'b0;
    check("wrap_count", 128'(word_count), 128'(0));
    tick();
    w1 = rand_word();
    in_data  = w1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("wrap_next_count", 128'(word_count), 128'(1));
    check("wrap_next_da", 128'(da), 128'(w1[W-1:DB_W]));
    check("wrap_next_db", 128'(db), 128'(w1[DB_W-1:0]));
    tick();
    tick();

    check("end_da_q_empty", 128'(exp_da_q.size()), 128'(0));
    check("end_db_q_empty", 128'(exp_db_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
